// File: rtl/cp2_host_port.sv
// rtl/cp2_host_port.sv - CPU-side CP2 initiator: op issue/data sequencing and exception latching
module cp2_host_port #(
  parameter int WORD_W      = 32,
  parameter int EXC_W       = 4,
  parameter int FDS_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic [1:0]        cpu_op,
  input  logic [WORD_W-1:0] cpu_ir,
  input  logic [WORD_W-1:0] cpu_wdata,
  output logic              cpu_accept,
  output logic              cpu_busy,
  output logic              cpu_done,
  output logic              cpu_err,
  output logic [WORD_W-1:0] cpu_rdata,
  output logic              cpu_irq,
  output logic [EXC_W-1:0]  cpu_exccode,
  output logic              cpu_exc_ovf,
  input  logic              cpu_exc_ack,
  output logic              cp2_irenable_0,
  output logic [WORD_W-1:0] cp2_ir_0,
  output logic              cp2_ts_0,
  output logic              cp2_fs_0,
  output logic              cp2_as_0,
  input  logic              cp2_tbusy_0,
  input  logic              cp2_fbusy_0,
  input  logic              cp2_abusy_0,
  output logic              cp2_tds_0,
  output logic [WORD_W-1:0] cp2_tdata_0,
  input  logic              cp2_fds_0,
  input  logic [WORD_W-1:0] cp2_fdata_0,
  input  logic              cp2_excs_0,
  input  logic              cp2_exc_0,
  input  logic [EXC_W-1:0]  cp2_exccode_0
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_TDATA, S_FWAIT, S_DONE} state_t;

  localparam logic [1:0]  OP_TS   = 2'b01;
  localparam logic [1:0]  OP_FS   = 2'b10;
  localparam logic [1:0]  OP_AS   = 2'b11;
  localparam logic [15:0] TIMEOUT = 16'(FDS_TIMEOUT);

  state_t            state, state_n;
  logic              req_q;
  logic [2:0]        busy_q;
  logic [1:0]        op_l;
  logic [WORD_W-1:0] ir_l, wdata_l, rdata_q;
  logic [15:0]       cnt;
  logic              err_q, class_busy, accept_ok, fwait_timeout, hold, exc_evt;
  logic              exc_pend;
  logic [EXC_W-1:0]  exc_code_q;
  logic              exc_ovf_q;

  // The accept decision uses the request snapshot taken on the previous edge,
  // so cpu_accept is a decode of flops and precedes the ISSUE cycle.
  always_comb begin
    class_busy = 1'b1;
    case (op_l)
      OP_TS:   class_busy = busy_q[0];
      OP_FS:   class_busy = busy_q[1];
      OP_AS:   class_busy = busy_q[2];
      default: class_busy = 1'b1;
    endcase
  end

  assign accept_ok     = (state == S_IDLE) && req_q && !class_busy;
  assign fwait_timeout = (state == S_FWAIT) && !cp2_fds_0 && (cnt == TIMEOUT);
  assign hold          = accept_ok || (state == S_ISSUE) || (state == S_TDATA);
  assign exc_evt       = cp2_exc_0 && cp2_excs_0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (accept_ok) state_n = S_ISSUE;
      S_ISSUE: begin
        case (op_l)
          OP_TS:   state_n = S_TDATA;
          OP_FS:   state_n = S_FWAIT;
          default: state_n = S_DONE;
        endcase
      end
      S_TDATA: state_n = S_DONE;
      S_FWAIT: begin
        if (cp2_fds_0)          state_n = S_DONE;
        else if (cnt == TIMEOUT) state_n = S_IDLE;
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    cpu_accept     = accept_ok;
    cpu_busy       = accept_ok || (state == S_ISSUE) || (state == S_TDATA) || (state == S_FWAIT);
    cpu_done       = (state == S_DONE);
    cp2_irenable_0 = (state == S_ISSUE);
    cp2_ir_0       = '0;
    cp2_ts_0       = 1'b0;
    cp2_fs_0       = 1'b0;
    cp2_as_0       = 1'b0;
    cp2_tds_0      = (state == S_TDATA);
    cp2_tdata_0    = '0;
    if (state == S_ISSUE) begin
      cp2_ir_0 = ir_l;
      cp2_ts_0 = (op_l == OP_TS);
      cp2_fs_0 = (op_l == OP_FS);
      cp2_as_0 = (op_l == OP_AS);
    end
    if (state == S_TDATA) cp2_tdata_0 = wdata_l;
  end

  // Op fields track the CPU until accepted and stay frozen while ISSUE/TDATA use them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_q   <= 1'b0;
      busy_q  <= '0;
      op_l    <= '0;
      ir_l    <= '0;
      wdata_l <= '0;
      cnt     <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      req_q  <= cpu_req;
      busy_q <= {cp2_abusy_0, cp2_fbusy_0, cp2_tbusy_0};
      if (!hold) begin
        op_l    <= cpu_op;
        ir_l    <= cpu_ir;
        wdata_l <= cpu_wdata;
      end
      cnt   <= (state == S_FWAIT) ? cnt + 16'd1 : 16'd0;
      err_q <= fwait_timeout;
      if ((state == S_FWAIT) && cp2_fds_0) rdata_q <= cp2_fdata_0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exc_pend   <= 1'b0;
      exc_code_q <= '0;
      exc_ovf_q  <= 1'b0;
    end else if (exc_evt) begin
      if (!exc_pend || cpu_exc_ack) begin
        exc_pend   <= 1'b1;
        exc_code_q <= cp2_exccode_0;
      end else begin
        exc_ovf_q <= 1'b1;
      end
    end else if (cpu_exc_ack) begin
      exc_pend <= 1'b0;
    end
  end

  assign cpu_err     = err_q;
  assign cpu_rdata   = rdata_q;
  assign cpu_irq     = exc_pend;
  assign cpu_exccode = exc_code_q;
  assign cpu_exc_ovf = exc_ovf_q;

endmodule
